// File: rtl/apb_cfg_master_pkg.sv
// Shared types for the APB configuration master: FSM state encoding and the
// registered response record returned on the host response port.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  localparam logic [31:0] RSP_ERR_RDATA = 32'h0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } apb_mst_rsp_t;

endpackage

// File: rtl/apb_cfg_master_if.sv
// Signal bundle for the host request/response port and the APB bus of
// apb_cfg_master; master modport is the initiator view, slave the peripheral view.
interface apb_cfg_master_if #(
  parameter int unsigned AW = 12
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_cfg_master_timeout.sv
// ACCESS-phase wait-state counter; flags the last permitted wait cycle.
// Saturates instead of wrapping; a zero limit disables it entirely.
module apb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk_i, rst_i, clear_i, enable_i};
      assign expired_o     = 1'b0;
    end else begin : g_cnt
      localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      localparam logic [CW-1:0] CAP  = CW'(TIMEOUT_CYCLES);

      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
          cnt_d = '0;
        end else if (enable_i && (cnt_q != CAP)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired_o = enable_i && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_cfg_master.sv
// APB3 initiator: one outstanding host request becomes a SETUP/ACCESS transfer,
// with wait states, slave error, bus timeout and misaligned-address rejection.
module apb_cfg_master
  import apb_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_write_i,
  input  logic [31:0]               req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  apb_mst_state_e            state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      write_q, write_d;
  logic [31:0]               wdata_q, wdata_d;
  apb_mst_rsp_t              rsp_q, rsp_d;
  logic                      tmo_clear, tmo_enable, tmo_expired;

  assign tmo_enable = (state_q == ACCESS) && !PREADY;

  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (HCLK),
    .rst_i    (HRESET),
    .clear_i  (tmo_clear),
    .enable_i (tmo_enable),
    .expired_o(tmo_expired)
  );

  // Bus address/data registers only load for aligned requests, so a rejected
  // misaligned request leaves the idle bus holding the previous transfer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    rsp_d     = rsp_q;
    tmo_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_addr_i[1:0] != 2'b00) begin
            rsp_d   = '{rdata: RSP_ERR_RDATA, err: 1'b1, timeout: 1'b0};
            state_d = RESP;
          end else begin
            addr_d    = req_addr_i;
            write_d   = req_write_i;
            wdata_d   = req_wdata_i;
            tmo_clear = 1'b1;
            state_d   = SETUP;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          rsp_d.rdata   = (write_q || PSLVERR) ? RSP_ERR_RDATA : PRDATA;
          rsp_d.err     = PSLVERR;
          rsp_d.timeout = 1'b0;
          state_d       = RESP;
        end else if (tmo_expired) begin
          rsp_d   = '{rdata: RSP_ERR_RDATA, err: 1'b1, timeout: 1'b1};
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = rsp_q.rdata;
  assign rsp_err_o     = rsp_q.err;
  assign rsp_timeout_o = rsp_q.timeout;
  assign PSEL          = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE       = (state_q == ACCESS);
  assign PADDR         = addr_q;
  assign PWRITE        = write_q;
  assign PWDATA        = wdata_q;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Directed bench for apb_cfg_master: stimulus pushes expected responses into a
// queue, a monitor pops and compares them on every response handshake.
module tb_apb_cfg_master;
  import apb_master_pkg::*;

  localparam int unsigned AW = 12;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  apb_cfg_master_if #(.AW(AW)) bus ();

  apb_cfg_master #(
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .req_valid_i  (bus.req_valid),
    .req_ready_o  (bus.req_ready),
    .req_addr_i   (bus.req_addr),
    .req_write_i  (bus.req_write),
    .req_wdata_i  (bus.req_wdata),
    .rsp_valid_o  (bus.rsp_valid),
    .rsp_ready_i  (bus.rsp_ready),
    .rsp_rdata_o  (bus.rsp_rdata),
    .rsp_err_o    (bus.rsp_err),
    .rsp_timeout_o(bus.rsp_timeout),
    .PADDR        (bus.paddr),
    .PWDATA       (bus.pwdata),
    .PWRITE       (bus.pwrite),
    .PSEL         (bus.psel),
    .PENABLE      (bus.penable),
    .PRDATA       (bus.prdata),
    .PREADY       (bus.pready),
    .PSLVERR      (bus.pslverr)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Peripheral model: PREADY after slv_wait ACCESS cycles; PRDATA/PSLVERR
  // carry garbage while not ready so early sampling would be visible.
  int          slv_wait  = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err   = 1'b0;
  int          acc_cnt   = 0;

  initial begin
    bus.pready  = 1'b0;
    bus.prdata  = 32'hDEAD_BEEF;
    bus.pslverr = 1'b1;
  end

  always @(negedge HCLK) begin
    if (bus.psel && bus.penable) begin
      bus.pready  = (acc_cnt == slv_wait);
      bus.prdata  = bus.pready ? slv_rdata : 32'hDEAD_BEEF;
      bus.pslverr = bus.pready ? slv_err : 1'b1;
      acc_cnt++;
    end else begin
      bus.pready  = 1'b0;
      bus.prdata  = 32'hDEAD_BEEF;
      bus.pslverr = 1'b1;
      acc_cnt     = 0;
    end
  end

  // Scoreboard and response monitor
  apb_mst_rsp_t exp_q[$];
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  apb_mst_rsp_t prev_rsp;
  int           rsp_seen   = 0;

  always @(negedge HCLK) begin
    apb_mst_rsp_t act, exp;
    act = '{rdata: bus.rsp_rdata, err: bus.rsp_err, timeout: bus.rsp_timeout};
    if (HRESET) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        chk("rsp_hold_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_hold_rdata", act.rdata, prev_rsp.rdata);
        chk("rsp_hold_flags", {30'd0, act.err, act.timeout}, {30'd0, prev_rsp.err, prev_rsp.timeout});
      end
      if (bus.rsp_valid) rsp_seen++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          exp = exp_q.pop_front();
          chk("rsp_rdata", act.rdata, exp.rdata);
          chk("rsp_err", 32'(act.err), 32'(exp.err));
          chk("rsp_timeout", 32'(act.timeout), 32'(exp.timeout));
        end
      end
      prev_valid = bus.rsp_valid;
      prev_ready = bus.rsp_ready;
      prev_rsp   = act;
    end
  end

  task automatic drive_point();
    @(posedge HCLK);
    #2;
  endtask

  // One aligned transfer; rsp_cyc is the cycle (after the c0 handshake) at
  // which rsp_valid_o is expected, every earlier cycle after c0 is on the bus.
  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                      input int waits, input logic [31:0] prd, input logic perr,
                      input int rsp_cyc, input apb_mst_rsp_t exp);
    drive_point();
    slv_wait      = waits;
    slv_rdata     = prd;
    slv_err       = perr;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_write = wr;
    bus.req_wdata = wdata;
    exp_q.push_back(exp);
    @(negedge HCLK);
    chk("c0_req_ready", 32'(bus.req_ready), 32'd1);
    for (int k = 1; k <= rsp_cyc; k++) begin
      drive_point();
      if (k == 1) bus.req_valid = 1'b0;
      @(negedge HCLK);
      chk("psel", 32'(bus.psel), 32'(k < rsp_cyc));
      chk("penable", 32'(bus.penable), 32'(k >= 2 && k < rsp_cyc));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(k == rsp_cyc));
      if (k < rsp_cyc) begin
        chk("paddr", 32'(bus.paddr), 32'(addr));
        chk("pwrite", 32'(bus.pwrite), 32'(wr));
        if (wr) chk("pwdata", bus.pwdata, wdata);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen_before;
    HRESET        = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_write = 1'b0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge HCLK);
    #2;
    @(negedge HCLK);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_psel_penable", {30'd0, bus.psel, bus.penable}, 32'd0);
    chk("rst_paddr", 32'(bus.paddr), 32'd0);
    chk("rst_pwdata", bus.pwdata, 32'd0);
    chk("rst_pwrite", 32'(bus.pwrite), 32'd0);
    chk("rst_rsp_fields", bus.rsp_rdata | 32'(bus.rsp_err) | 32'(bus.rsp_timeout), 32'd0);
    drive_point();
    HRESET = 1'b0;

    // zero-wait write, 3-wait read, slave error, timeout after 16 ACCESS cycles
    xfer(12'h01C, 1'b1, 32'h0707_0707, 0, 32'h1111_2222, 1'b0, 3, '{32'h0, 1'b0, 1'b0});
    xfer(12'h010, 1'b0, 32'h0, 3, 32'h0004_0001, 1'b0, 6, '{32'h0004_0001, 1'b0, 1'b0});
    xfer(12'h040, 1'b0, 32'h0, 0, 32'h5555_AAAA, 1'b1, 3, '{32'h0, 1'b1, 1'b0});
    xfer(12'h044, 1'b0, 32'h0, 1000, 32'h0, 1'b0, 18, '{32'h0, 1'b1, 1'b1});

    // Misaligned request with a stalled response and a second request queued
    drive_point();
    slv_wait      = 0;
    slv_err       = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 12'h00A;
    bus.req_write = 1'b0;
    exp_q.push_back('{32'h0, 1'b1, 1'b0});
    @(negedge HCLK);
    chk("mis_c0_req_ready", 32'(bus.req_ready), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      drive_point();
      if (k == 1) begin
        bus.req_addr  = 12'h020;
        bus.req_write = 1'b1;
        bus.req_wdata = 32'hCAFE_0001;
        exp_q.push_back('{32'h0, 1'b0, 1'b0});
      end
      if (k == 6) bus.rsp_ready = 1'b1;
      @(negedge HCLK);
      chk("mis_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("mis_no_psel", 32'(bus.psel), 32'd0);
      chk("mis_busy_req_ready", 32'(bus.req_ready), 32'd0);
      chk("mis_idle_paddr_hold", 32'(bus.paddr), 32'h044);
    end
    drive_point();
    @(negedge HCLK);
    chk("b2b_req_ready", 32'(bus.req_ready), 32'd1);
    chk("b2b_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    drive_point();
    bus.req_valid = 1'b0;
    @(negedge HCLK);
    chk("b2b_psel", {30'd0, bus.psel, bus.penable}, 32'd2);
    chk("b2b_paddr", 32'(bus.paddr), 32'h020);
    chk("b2b_pwdata", bus.pwdata, 32'hCAFE_0001);
    repeat (2) drive_point();
    @(negedge HCLK);
    chk("b2b_rsp_valid_c3", 32'(bus.rsp_valid), 32'd1);

    // Reset in the middle of ACCESS drops the transfer
    drive_point();
    slv_wait      = 1000;
    bus.req_valid = 1'b1;
    bus.req_addr  = 12'h030;
    bus.req_write = 1'b0;
    drive_point();
    bus.req_valid = 1'b0;
    drive_point();
    drive_point();
    @(negedge HCLK);
    chk("rst_mid_access", {30'd0, bus.psel, bus.penable}, 32'd3);
    #1;
    HRESET = 1'b1;
    drive_point();
    @(negedge HCLK);
    chk("rst_mid_psel_penable", {30'd0, bus.psel, bus.penable}, 32'd0);
    chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
    drive_point();
    HRESET = 1'b0;
    seen_before = rsp_seen;
    repeat (20) drive_point();
    @(negedge HCLK);
    chk("rst_no_rsp", 32'(rsp_seen - seen_before), 32'd0);
    chk("rst_idle_psel", 32'(bus.psel), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
